// File: rtl/fpaddsub_pkg.sv
// Shared widths and the stage payload for the FP add/sub normalise-and-round pipeline.
package fpaddsub_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int EXP_BIAS = 127;

  // exp is one bit wider so a carry out of 8'hFE can still be detected as overflow.
  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   exp;
    logic [MAN_W:0]   man;
    logic             g;
    logic             r;
    logic             s;
    logic             special;
    logic             zero;
    logic             flush;
  } stage_t;
endpackage

// File: rtl/fpaddsub_normalize_round_if.sv
// Upstream result bus plus downstream packed-result bus, both valid/ready.
interface fpaddsub_normalize_round_if;
  logic        InValid;
  logic        InReady;
  logic        Sgn;
  logic [7:0]  Es;
  logic [24:0] Sum;
  logic        GuardBit;
  logic        RoundBit;
  logic        StickyBit;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Z;
  logic        Overflow;
  logic        Underflow;
  logic        Inexact;
  logic        ZeroOut;

  modport master (
    output InValid, Sgn, Es, Sum, GuardBit, RoundBit, StickyBit, OutReady,
    input  InReady, OutValid, Z, Overflow, Underflow, Inexact, ZeroOut
  );
  modport slave (
    input  InValid, Sgn, Es, Sum, GuardBit, RoundBit, StickyBit, OutReady,
    output InReady, OutValid, Z, Overflow, Underflow, Inexact, ZeroOut
  );
endinterface

// File: rtl/fpaddsub_lzc26.sv
// Combinational leading-zero counter over 26 bits; all-zero input gives 26.
module fpaddsub_lzc26 (
  input  logic [25:0] x,
  output logic [4:0]  cnt
);
  always_comb begin
    cnt = 5'd26;
    // Ascending scan: the highest set bit is the last one to write cnt.
    for (int i = 0; i < 26; i++)
      if (x[i]) cnt = 5'(25 - i);
  end
endmodule

// File: rtl/fpaddsub_normalize_round.sv
// Three-stage normalise / round-to-nearest-even / pack stage of the FP adder.
// S1: carry fix + LZC, S2: left shift or flush, S3: round, overflow, pack.
module fpaddsub_normalize_round
  import fpaddsub_pkg::*;
#(
  parameter bit ROUND_EN  = 1'b1,
  parameter bit FLUSH_SUB = 1'b1
) (
  input logic CLK,
  input logic RST_N,
  fpaddsub_normalize_round_if.slave bus
);
  localparam int STAGES = 3;

  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] load;
  logic            live;
  logic            accept;

  stage_t          s1_d, s1_q, s2_d, s2_q;
  logic [4:0]      lz_d, lz_q;
  logic [25:0]     mgr_sh;

  logic            inc, carry;
  logic [MAN_W-1:0] frac_rnd;
  logic [EXP_W:0]  e_rnd;
  logic [31:0]     z_d, z_q;
  logic            ovf_d, unf_d, inx_d, zro_d;
  logic            ovf_q, unf_q, inx_q, zro_q;

  // A stage takes new data when empty or when its successor is taking its contents.
  assign load[3]     = ~vld_pipe[3] | bus.OutReady;
  assign load[2]     = ~vld_pipe[2] | load[3];
  assign load[1]     = ~vld_pipe[1] | load[2];
  assign bus.InReady = live & load[1];
  assign accept      = bus.InValid & bus.InReady;

  // S1: fold the carry back into the 24-bit mantissa, demoting bits into g/r/s.
  always_comb begin
    s1_d         = '0;
    s1_d.sign    = bus.Sgn;
    s1_d.special = (bus.Es == EXP_MAX);
    if (bus.Sum[24] && !s1_d.special) begin
      s1_d.man = bus.Sum[24:1];
      s1_d.g   = bus.Sum[0];
      s1_d.r   = bus.GuardBit;
      s1_d.s   = bus.RoundBit | bus.StickyBit;
      s1_d.exp = {1'b0, bus.Es} + {{EXP_W{1'b0}}, 1'b1};
    end else begin
      s1_d.man = bus.Sum[23:0];
      s1_d.g   = bus.GuardBit;
      s1_d.r   = bus.RoundBit;
      s1_d.s   = bus.StickyBit;
      s1_d.exp = {1'b0, bus.Es};
    end
    s1_d.zero  = !s1_d.special && ({s1_d.man, s1_d.g, s1_d.r} == '0) && !s1_d.s;
    s1_d.flush = !s1_d.special && ({s1_d.man, s1_d.g, s1_d.r} == '0) && s1_d.s;
  end

  fpaddsub_lzc26 u_lzc (
    .x   ({s1_d.man, s1_d.g, s1_d.r}),
    .cnt (lz_d)
  );

  // S2: normalise, or flush when the shift would push the exponent to <= 0.
  always_comb begin
    s2_d   = s1_q;
    mgr_sh = '0;
    if (!s1_q.special && !s1_q.zero && !s1_q.flush) begin
      if (FLUSH_SUB && ({{(EXP_W-4){1'b0}}, lz_q} >= s1_q.exp)) begin
        s2_d.flush = 1'b1;
      end else begin
        mgr_sh   = {s1_q.man, s1_q.g, s1_q.r} << lz_q;
        s2_d.man = mgr_sh[25:2];
        s2_d.g   = mgr_sh[1];
        s2_d.r   = mgr_sh[0];
        s2_d.exp = s1_q.exp - {{(EXP_W-4){1'b0}}, lz_q};
      end
    end
  end

  // S3: a mantissa carry only happens from all-ones, so the fraction wraps to 0.
  always_comb begin
    inc      = ROUND_EN & s2_q.g & (s2_q.r | s2_q.s | s2_q.man[0]);
    carry    = inc & (&s2_q.man);
    frac_rnd = s2_q.man[MAN_W-1:0] + {{(MAN_W-1){1'b0}}, inc};
    e_rnd    = s2_q.exp + {{EXP_W{1'b0}}, carry};
    z_d   = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
    zro_d = 1'b0;
    if (s2_q.special) begin
      z_d = {s2_q.sign, EXP_MAX, s2_q.man[MAN_W-1:0]};
    end else if (s2_q.zero) begin
      zro_d = 1'b1;
    end else if (s2_q.flush) begin
      z_d   = {s2_q.sign, 31'b0};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else if (e_rnd >= {1'b0, EXP_MAX}) begin
      z_d   = {s2_q.sign, EXP_MAX, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else begin
      z_d   = {s2_q.sign, e_rnd[EXP_W-1:0], frac_rnd};
      inx_d = s2_q.g | s2_q.r | s2_q.s;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe <= '0;
      live     <= 1'b0;
      z_q      <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
      zro_q    <= 1'b0;
    end else begin
      live <= 1'b1;
      if (load[1]) vld_pipe[1] <= accept;
      if (load[2]) vld_pipe[2] <= vld_pipe[1];
      if (load[3]) vld_pipe[3] <= vld_pipe[2];
      if (load[3] && vld_pipe[2]) begin
        z_q   <= z_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        inx_q <= inx_d;
        zro_q <= zro_d;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      s1_q <= s1_d;
      lz_q <= lz_d;
    end
    if (load[2] && vld_pipe[1]) s2_q <= s2_d;
  end

  assign bus.OutValid  = vld_pipe[3];
  assign bus.Z         = z_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;
  assign bus.Inexact   = inx_q;
  assign bus.ZeroOut   = zro_q;
endmodule

// File: doc/fpaddsub_normalize_round.md
Name: fpaddsub_normalize_round

Overview:
Downstream stage of the single-precision FP adder/subtractor. It consumes the raw aligned-and-executed result: sign, common exponent, 25-bit sum with carry, and guard/round/sticky bits. It normalises, rounds (round-to-nearest-even), handles exponent overflow/underflow and packs the IEEE-754 word Z. It is a 3-stage valid/ready pipeline so the adder datapath can be registered and back-pressured.

Parameters:
ROUND_EN, 1, 1 = round-to-nearest-even; 0 = truncate (increment forced to 0)
FLUSH_SUB, 1, 1 = results with exponent <= 0 flush to signed zero (only supported setting)

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
InValid  input  1  upstream result valid
InReady  output  1  stage can accept; transfer when InValid & InReady
Sgn  input  1  result sign from execute stage
Es  input  8  common (larger) exponent after alignment
Sum  input  25  [24]=carry, [23]=hidden bit, [22:0]=fraction
GuardBit  input  1  first bit below Sum[0]
RoundBit  input  1  second bit below Sum[0]
StickyBit  input  1  OR of all lower shifted-out bits
OutValid  output  1  Z and flags valid
OutReady  input  1  downstream accepts; transfer when OutValid & OutReady
Z  output  32  packed result {sign, exp[7:0], frac[22:0]}
Overflow  output  1  result rounded to infinity
Underflow  output  1  result flushed to zero from non-zero input
Inexact  output  1  any of G/R/S set before rounding, or underflow
ZeroOut  output  1  exact zero result

Behaviour:
- Reset: the three stage-valid bits, OutValid, Z and all flags go to 0. InReady is 1 one cycle after reset deasserts. Reset mid-operation discards in-flight data.
- Handshake: stage k loads when its valid is 0 or stage k+1 is loading/draining. Out stage drains on OutReady. InReady = ~v1 | advance1. Latency is 3 cycles from accept to OutValid with no stall. Full throughput is 1/cycle. Data must be held (no loss, no duplication) under any OutReady pattern.
- Special input: Es==8'hFF passes through as {Sgn, 8'hFF, Sum[22:0]} with all flags 0.
- S1 (carry fix + LZC):
  - If Sum[24]: m = Sum[24:1], g = Sum[0], r = GuardBit, s = RoundBit | StickyBit, e = Es+1 (9-bit).
  - Else: m = Sum[23:0], g/r/s passed through, e = {0, Es}.
  - lz = leading-zero count of the 26-bit {m, g, r}, range 0..26.
- S2 (left shift):
  - If {m, g, r} == 0 and s == 0: exact zero; ZeroOut=1, Z=32'h0 (sign forced +).
  - Else if lz == 26 or lz >= e: flush; Z = {Sgn, 31'b0}, Underflow=1, Inexact=1.
  - Else: {m, g, r} <<= lz (zeros shifted in), s unchanged, e -= lz.
- S3 (round + pack):
  - inc = ROUND_EN & g & (r | s | m[0]).
  - m' = m + inc. If m' carries past bit 23: m' = 24'h800000, e += 1.
  - If e >= 255: Z = {Sgn, 8'hFF, 23'h0}, Overflow=1, Inexact=1.
  - Else: Z = {Sgn, e[7:0], m'[22:0]}, Inexact = g | r | s.
- Flags are registered alongside Z and valid only with OutValid. Flags are mutually exclusive except Inexact.

Decomposition:
- Shared package fpaddsub_pkg: EXP_W=8, MAN_W=23, EXP_MAX=8'hFF, EXP_BIAS=127, and the stage payload struct (sign, 9-bit exp, 24-bit mantissa, g, r, s, special, zero, flags).
- One sub-module, fpaddsub_lzc26: combinational 26-bit leading-zero counter, 5-bit count, 26 when all-zero.

Test Plan:
- 1.0+1.0: Es=8'h7F, Sum=25'h1000000, GRS=000 -> Z=32'h40000000 exactly 3 cycles after accept, no flags.
- Cancellation: Es=8'h7F, Sum=25'h0000001, GRS=000 -> lz=23, Z=32'h34000000; Es=8'h05, Sum=25'h0000100 -> Z=32'h00000000 (Sgn=0), Underflow=1, Inexact=1.
- RNE: Es=8'h7F, Sum=25'h0800001, GRS=100 -> Z=32'h3F800002, Inexact=1; Sum=25'h0800000, GRS=100 -> Z=32'h3F800000 (tie to even); with ROUND_EN=0 the first case gives 32'h3F800001.
- Overflow and mantissa carry:
  - Es=8'hFE, Sum=25'h1FFFFFF, GRS=100, Sgn=1 -> Z=32'hFF800000, Overflow=1.
  - Es=8'h7F, Sum=25'h0FFFFFF, GRS=110 -> Z=32'h40000000.
- Zero and special: Sum=0, GRS=000, Es=8'h80 -> Z=0, ZeroOut=1; Es=8'hFF, Sum[22:0]=23'h400000, Sgn=0 -> Z=32'h7FC00000, no flags.
- Back-pressure/reset:
  - Stream 6 back-to-back inputs with OutReady=0 for 5 cycles -> InReady drops after 3 accepted; outputs appear in order with no loss or duplication.
  - Assert RST_N low with 2 in flight -> OutValid=0 immediately, and no stale output after reset release.
